// File: rtl/mac_cfg_apb_slave.sv
// APB3 responder for the MAC configuration bus: MAC1/MAC2/FIR registers plus a
// read-only status word, with optional wait states and slave-error reporting.
module mac_cfg_apb_slave #(
  parameter string SPEED_TYPE  = "10/100/1000M_MAC",
  parameter int    WAIT_STATES = 0
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        pselx,
  input  logic        pwrite,
  input  logic        penable,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [15:0] mac1_cfg,
  output logic [15:0] mac2_cfg,
  output logic [15:0] fir_cfg,
  output logic        cfg_valid,
  output logic [2:0]  cfg_wr_strobe
);

  localparam logic [15:0] MAC2_RST  = (SPEED_TYPE == "10/100M_MAC") ? 16'h7111 : 16'h7211;
  localparam logic [1:0]  WAIT_INIT = 2'(WAIT_STATES);

  localparam logic [7:0] ADDR_MAC1 = 8'h00;
  localparam logic [7:0] ADDR_MAC2 = 8'h01;
  localparam logic [7:0] ADDR_FIR  = 8'h12;
  localparam logic [7:0] ADDR_STAT = 8'h13;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] prdata_q, prdata_d;
  logic [15:0] mac1_q, mac1_d;
  logic [15:0] mac2_q, mac2_d;
  logic [15:0] fir_q, fir_d;
  logic [2:0]  written_q, written_d;
  logic [7:0]  wcount_q, wcount_d;
  logic [2:0]  strobe_q, strobe_d;

  logic        pready_s;
  logic        cfg_valid_s;
  logic [31:0] status_s;
  logic        unused_pwdata_s;

  function automatic logic addr_err(input logic [7:0] addr, input logic wr);
    logic err;
    case (addr)
      ADDR_MAC1, ADDR_MAC2, ADDR_FIR: err = 1'b0;
      ADDR_STAT:                      err = wr;
      default:                        err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] read_mux(input logic [7:0]  addr,
                                           input logic [15:0] mac1,
                                           input logic [15:0] mac2,
                                           input logic [15:0] fir,
                                           input logic [31:0] status);
    logic [31:0] data;
    case (addr)
      ADDR_MAC1: data = {16'h0000, mac1};
      ADDR_MAC2: data = {16'h0000, mac2};
      ADDR_FIR:  data = {16'h0000, fir};
      ADDR_STAT: data = status;
      default:   data = 32'h0000_0000;
    endcase
    return data;
  endfunction

  // Upper write-data bits have no storage behind them.
  assign unused_pwdata_s = ^pwdata[31:16];

  assign cfg_valid_s = &written_q;
  assign status_s    = {16'h0000, wcount_q, 7'b000_0000, cfg_valid_s};
  assign pready_s    = (state_q == ST_ACCESS) && pselx && penable && (wait_q == 2'd0);

  // Next-state, transfer capture and register commit.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wait_d    = wait_q;
    prdata_d  = prdata_q;
    mac1_d    = mac1_q;
    mac2_d    = mac2_q;
    fir_d     = fir_q;
    written_d = written_q;
    wcount_d  = wcount_q;
    strobe_d  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (pselx && !penable) begin
          state_d = ST_ACCESS;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata[15:0];
          err_d   = addr_err(paddr, pwrite);
          wait_d  = WAIT_INIT;
          if (!pwrite) begin
            prdata_d = read_mux(paddr, mac1_q, mac2_q, fir_q, status_s);
          end else begin
            prdata_d = prdata_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A dropped select abandons the transfer with nothing committed.
        if (!pselx) begin
          state_d = ST_IDLE;
        end else if (pready_s) begin
          state_d = ST_IDLE;
          if (write_q && !err_q) begin
            wcount_d = (wcount_q == 8'hFF) ? wcount_q : wcount_q + 8'd1;
            case (addr_q)
              ADDR_MAC1: begin
                mac1_d       = wdata_q;
                written_d[0] = 1'b1;
                strobe_d     = 3'b001;
              end
              ADDR_MAC2: begin
                mac2_d       = wdata_q;
                written_d[1] = 1'b1;
                strobe_d     = 3'b010;
              end
              ADDR_FIR: begin
                fir_d        = wdata_q;
                written_d[2] = 1'b1;
                strobe_d     = 3'b100;
              end
              default: strobe_d = 3'b000;
            endcase
          end else begin
            wcount_d = wcount_q;
          end
        end else if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end else begin
          wait_d = wait_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register file.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= 8'h00;
      write_q   <= 1'b0;
      wdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      wait_q    <= 2'd0;
      prdata_q  <= 32'h0000_0000;
      mac1_q    <= 16'h0000;
      mac2_q    <= MAC2_RST;
      fir_q     <= 16'h0000;
      written_q <= 3'b000;
      wcount_q  <= 8'h00;
      strobe_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      prdata_q  <= prdata_d;
      mac1_q    <= mac1_d;
      mac2_q    <= mac2_d;
      fir_q     <= fir_d;
      written_q <= written_d;
      wcount_q  <= wcount_d;
      strobe_q  <= strobe_d;
    end
  end

  assign prdata        = prdata_q;
  assign pready        = pready_s;
  assign pslverr       = pready_s && err_q;
  assign mac1_cfg      = mac1_q;
  assign mac2_cfg      = mac2_q;
  assign fir_cfg       = fir_q;
  assign cfg_valid     = cfg_valid_s;
  assign cfg_wr_strobe = strobe_q;

endmodule

// File: tb/tb_mac_cfg_apb_slave.sv
// Bench for mac_cfg_apb_slave: two instances (no wait states / two wait states,
// different SPEED_TYPE) driven with directed and random APB traffic against a model.
module tb_mac_cfg_apb_slave;

  logic        clk = 1'b0;
  logic        presetn;
  int          tgt;
  logic        b_psel, b_en, b_wr;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        psel0, psel1;

  logic [1:0][31:0] o_prdata;
  logic [1:0]       o_pready, o_pslverr, o_valid;
  logic [1:0][15:0] o_mac1, o_mac2, o_fir;
  logic [1:0][2:0]  o_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_mac1 [2];
  logic [15:0] m_mac2 [2];
  logic [15:0] m_fir  [2];
  logic [2:0]  m_mask [2];
  int          m_cnt  [2];
  logic [2:0]  m_strobe [2];
  logic        e_pready, e_pslverr, e_rd_chk;
  logic [31:0] e_prdata;

  assign psel0 = b_psel && (tgt == 0);
  assign psel1 = b_psel && (tgt == 1);

  always #5 clk = ~clk;

  mac_cfg_apb_slave #(.WAIT_STATES(0)) dut0 (
    .pclk(clk), .presetn(presetn), .pselx(psel0), .pwrite(b_wr), .penable(b_en),
    .paddr(b_addr), .pwdata(b_wdata), .prdata(o_prdata[0]), .pready(o_pready[0]),
    .pslverr(o_pslverr[0]), .mac1_cfg(o_mac1[0]), .mac2_cfg(o_mac2[0]), .fir_cfg(o_fir[0]),
    .cfg_valid(o_valid[0]), .cfg_wr_strobe(o_strobe[0])
  );

  mac_cfg_apb_slave #(.SPEED_TYPE("10/100M_MAC"), .WAIT_STATES(2)) dut1 (
    .pclk(clk), .presetn(presetn), .pselx(psel1), .pwrite(b_wr), .penable(b_en),
    .paddr(b_addr), .pwdata(b_wdata), .prdata(o_prdata[1]), .pready(o_pready[1]),
    .pslverr(o_pslverr[1]), .mac1_cfg(o_mac1[1]), .mac2_cfg(o_mac2[1]), .fir_cfg(o_fir[1]),
    .cfg_valid(o_valid[1]), .cfg_wr_strobe(o_strobe[1])
  );

  function automatic int ws_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic logic [15:0] mac2_rst(input int i);
    return (i == 1) ? 16'h7111 : 16'h7211;
  endfunction

  function automatic bit m_is_err(input logic [7:0] a, input bit wr);
    if (a == 8'h13) return wr;
    return !(a == 8'h00 || a == 8'h01 || a == 8'h12);
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [7:0] a);
    if (a == 8'h00) return {16'h0000, m_mac1[i]};
    if (a == 8'h01) return {16'h0000, m_mac2[i]};
    if (a == 8'h12) return {16'h0000, m_fir[i]};
    if (a == 8'h13) return 32'(m_cnt[i] * 256 + ((m_mask[i] == 3'b111) ? 1 : 0));
    return 32'h0000_0000;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_mac1[i]   = 16'h0000;
      m_mac2[i]   = mac2_rst(i);
      m_fir[i]    = 16'h0000;
      m_mask[i]   = 3'b000;
      m_cnt[i]    = 0;
      m_strobe[i] = 3'b000;
    end
    e_pready  = 1'b0;
    e_pslverr = 1'b0;
    e_rd_chk  = 1'b0;
    e_prdata  = 32'h0000_0000;
  endtask

  task automatic m_commit(input int i, input logic [7:0] a, input logic [31:0] d);
    if (a == 8'h00) begin
      m_mac1[i] = d[15:0]; m_mask[i][0] = 1'b1; m_strobe[i] = 3'b001;
    end else if (a == 8'h01) begin
      m_mac2[i] = d[15:0]; m_mask[i][1] = 1'b1; m_strobe[i] = 3'b010;
    end else begin
      m_fir[i] = d[15:0]; m_mask[i][2] = 1'b1; m_strobe[i] = 3'b100;
    end
    if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes last one cycle: every cycle advance clears the expected pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) m_strobe[i] = 3'b000;
  endtask

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mac1_cfg[%0d]", i), 32'(o_mac1[i]), 32'(m_mac1[i]));
      chk($sformatf("mac2_cfg[%0d]", i), 32'(o_mac2[i]), 32'(m_mac2[i]));
      chk($sformatf("fir_cfg[%0d]", i), 32'(o_fir[i]), 32'(m_fir[i]));
      chk($sformatf("cfg_valid[%0d]", i), 32'(o_valid[i]), 32'(m_mask[i] == 3'b111));
      chk($sformatf("strobe[%0d]", i), 32'(o_strobe[i]), 32'(m_strobe[i]));
      if (i == tgt) begin
        chk($sformatf("pready[%0d]", i), 32'(o_pready[i]), 32'(e_pready));
        chk($sformatf("pslverr[%0d]", i), 32'(o_pslverr[i]), 32'(e_pslverr));
        if (e_rd_chk) chk($sformatf("prdata[%0d]", i), o_prdata[i], e_prdata);
      end else begin
        chk($sformatf("idle_pready[%0d]", i), 32'(o_pready[i]), 32'h0);
        chk($sformatf("idle_pslverr[%0d]", i), 32'(o_pslverr[i]), 32'h0);
      end
    end
  end

  // One APB transfer; abort_k >= 0 drops pselx in that access cycle.
  task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input int abort_k, output logic [31:0] rd);
    int          ws;
    bit          err;
    logic [31:0] exp_rd;
    ws     = ws_of(i);
    err    = m_is_err(a, wr);
    exp_rd = m_read(i, a);
    tgt    = i;
    b_psel = 1'b1; b_en = 1'b0; b_wr = wr; b_addr = a; b_wdata = d;
    e_pready = 1'b0; e_pslverr = 1'b0; e_rd_chk = 1'b0;
    tick();
    b_en = 1'b1;
    for (int k = 0; k <= ws; k++) begin
      if (k == abort_k) begin
        b_psel = 1'b0; b_en = 1'b0;
        e_pready = 1'b0; e_pslverr = 1'b0; e_rd_chk = 1'b0;
        tick();
        rd = o_prdata[i];
        return;
      end
      e_pready  = (k == ws);
      e_pslverr = (k == ws) && err;
      e_rd_chk  = !wr;
      e_prdata  = exp_rd;
      tick();
    end
    if (wr && !err) m_commit(i, a, d);
    b_psel = 1'b0; b_en = 1'b0;
    e_pready = 1'b0; e_pslverr = 1'b0; e_rd_chk = 1'b0;
    rd = o_prdata[i];
  endtask

  initial begin
    logic [31:0] rd;
    presetn = 1'b0;
    tgt = 0;
    b_psel = 1'b0; b_en = 1'b0; b_wr = 1'b0; b_addr = 8'h00; b_wdata = 32'h0;
    m_reset();
    tick(); tick();
    presetn = 1'b1;
    tick();

    xfer(0, 1'b0, 8'h00, 32'h0, -1, rd); chk("rd_mac1_rst", rd, 32'h0000_0000);
    xfer(0, 1'b0, 8'h01, 32'h0, -1, rd); chk("rd_mac2_rst", rd, 32'h0000_7211);
    xfer(0, 1'b0, 8'h12, 32'h0, -1, rd); chk("rd_fir_rst", rd, 32'h0000_0000);
    xfer(0, 1'b0, 8'h13, 32'h0, -1, rd); chk("rd_stat_rst", rd, 32'h0000_0000);
    xfer(1, 1'b0, 8'h01, 32'h0, -1, rd); chk("rd_mac2_rst_100m", rd, 32'h0000_7111);

    xfer(0, 1'b1, 8'h00, 32'h0000_0035, -1, rd);
    xfer(0, 1'b1, 8'h01, 32'h0000_7211, -1, rd);
    chk("valid_before_third", 32'(o_valid[0]), 32'h0);
    xfer(0, 1'b1, 8'h12, 32'h0000_0080, -1, rd);
    chk("lit_mac1", 32'(o_mac1[0]), 32'h0035);
    chk("lit_fir", 32'(o_fir[0]), 32'h0080);
    chk("lit_valid", 32'(o_valid[0]), 32'h1);
    xfer(0, 1'b0, 8'h13, 32'h0, -1, rd); chk("lit_status", rd, 32'h0000_0301);

    xfer(0, 1'b1, 8'h05, 32'hFFFF_FFFF, -1, rd);
    xfer(0, 1'b1, 8'h13, 32'hFFFF_FFFF, -1, rd);
    xfer(0, 1'b0, 8'h13, 32'h0, -1, rd); chk("lit_status_after_err", rd, 32'h0000_0301);
    xfer(0, 1'b0, 8'h05, 32'h0, -1, rd); chk("lit_err_read", rd, 32'h0000_0000);

    xfer(1, 1'b1, 8'h00, 32'hABCD_1234, -1, rd);
    chk("lit_ws2_mac1", 32'(o_mac1[1]), 32'h1234);
    xfer(1, 1'b1, 8'h01, 32'h0000_5555, 1, rd);
    chk("lit_abort_mac2", 32'(o_mac2[1]), 32'h7111);
    xfer(1, 1'b1, 8'h12, 32'h0000_0042, -1, rd);
    xfer(1, 1'b0, 8'h13, 32'h0, -1, rd); chk("lit_ws2_status", rd, 32'h0000_0200);

    for (int n = 0; n < 300; n++) begin
      int          sel;
      bit          wr;
      logic [7:0]  a;
      int          ab;
      sel = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 8'h00;
        1:       a = 8'h01;
        2:       a = 8'h12;
        3:       a = 8'h13;
        default: a = 8'($urandom_range(0, 255));
      endcase
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ws_of(sel)) : -1;
      xfer(sel, wr, a, $urandom, ab, rd);
      if ($urandom_range(0, 3) == 0) tick();
    end

    for (int n = 0; n < 260; n++) xfer(0, 1'b1, 8'h00, 32'(n), -1, rd);
    xfer(0, 1'b0, 8'h13, 32'h0, -1, rd); chk("lit_count_sat", rd, 32'h0000_FF01);

    tgt = 0;
    b_psel = 1'b1; b_en = 1'b0; b_wr = 1'b1; b_addr = 8'h12; b_wdata = 32'h0000_0055;
    e_pready = 1'b0; e_pslverr = 1'b0; e_rd_chk = 1'b0;
    tick();
    b_en = 1'b1;
    presetn = 1'b0;
    m_reset();
    tick(); tick();
    presetn = 1'b1;
    tick();
    b_psel = 1'b0; b_en = 1'b0;
    tick();
    chk("rst_fir", 32'(o_fir[0]), 32'h0000);
    chk("rst_valid", 32'(o_valid[0]), 32'h0);
    chk("rst_pready", 32'(o_pready[0]), 32'h0);
    xfer(0, 1'b0, 8'h13, 32'h0, -1, rd); chk("rst_status", rd, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_cfg_apb_slave.md
# mac_cfg_apb_slave

APB3 responder that terminates the MAC configuration bus driven by the configuration sequencer. It holds the MAC1, MAC2 and frame-interval (FIR) configuration registers and a read-only status register. It drives the decoded configuration fields into the MAC core and supports optional wait states and slave-error reporting.

## Interface
- SPEED_TYPE, "10/100/1000M_MAC", selects the MAC2 reset value: "10/100M_MAC" gives 0x0000_7111; any other value gives 0x0000_7211.
- WAIT_STATES, 0, number of extra access-phase cycles before pready rises (0..3).
- pclk  in  1  APB clock; the only clock in the block.
- presetn  in  1  asynchronous, active-low reset.
- pselx  in  1  APB select.
- pwrite  in  1  1 = write, 0 = read.
- penable  in  1  APB enable (access phase).
- paddr  in  8  register address.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid in the access phase.
- pready  out  1  transfer completes in the current cycle.
- pslverr  out  1  error response; valid only while pready = 1.
- mac1_cfg  out  16  MAC1 register bits [15:0].
- mac2_cfg  out  16  MAC2 register bits [15:0]; bits [9:8] are the speed field.
- fir_cfg  out  16  FIR register bits [15:0].
- cfg_valid  out  1  high once MAC1, MAC2 and FIR have each been written at least once.
- cfg_wr_strobe  out  3  one-cycle one-hot pulse per committed write: bit0 = MAC1, bit1 = MAC2, bit2 = FIR.

## Operation
- Register map:
  - 0x00 MAC1: RW, bits [15:0], reset 0.
  - 0x01 MAC2: RW, bits [15:0], reset set by SPEED_TYPE.
  - 0x12 FIR: RW, bits [15:0], reset 0.
  - 0x13 STATUS: RO. Bit 0 = cfg_valid; bits [15:8] = count of committed writes, saturating at 255.
  - All RW registers ignore pwdata[31:16] and read those bits back as 0.
- Errors: any other address, or a write to 0x13, sets pslverr = 1 at completion. No register changes, and prdata reads 0.
- FSM has two states:
  - IDLE → ACCESS on pselx = 1 and penable = 0 (setup phase). On that edge the block latches paddr, pwrite and pwdata, the error flag, prdata (for reads) and the wait counter (loaded with WAIT_STATES).
  - ACCESS → IDLE on the edge where pready = 1, or immediately if pselx drops (abort: nothing committed, no strobe).
  - In IDLE, penable = 1 without a preceding setup phase is ignored.
- Wait counter: decrements each ACCESS cycle while it is non-zero. pready = ACCESS & pselx & penable & (counter == 0), combinational.
- Commit: a write without error updates its register on the edge where pready = 1. The write count increments on the same edge.
- cfg_valid: sticky; cleared only by reset.
- Back-to-back transfers: a new setup phase on the cycle after completion (pselx held high, penable low) is accepted.

## Timing
- Reset values:
  - prdata = 0, pready = 0, pslverr = 0.
  - mac1_cfg = 0, mac2_cfg = 0x7211 (default SPEED_TYPE), fir_cfg = 0.
  - cfg_valid = 0, cfg_wr_strobe = 0, write count = 0, FSM = IDLE.
- With WAIT_STATES = 0, pready rises in the first access cycle: 2-cycle transfer, no wait states.
- With WAIT_STATES = N, pready rises after N extra access cycles: transfer length 2 + N.
- Outputs after a commit:
  - mac*_cfg/fir_cfg take the new value in the cycle after the commit edge.
  - cfg_wr_strobe pulses in that same cycle, for exactly one cycle.
  - cfg_valid rises in that same cycle if the commit completed the set.
- prdata is stable for the whole access phase. Outside ACCESS it holds its last value; pslverr is 0 outside ACCESS.
- Reset asserted mid-transfer: all state and registers return to reset values immediately. The interrupted write is not committed.
- Write count at 255 stays at 255.

## Test plan
- Reset, then read 0x00, 0x01, 0x12, 0x13 → 0x0, 0x7211, 0x0, 0x0; pslverr = 0 on all four.
- Write 0x35 → 0x00, then 0x7211 → 0x01, then 0x80 → 0x12, each with pselx/penable held one cycle:
  - mac1_cfg = 0x0035, mac2_cfg = 0x7211, fir_cfg = 0x0080.
  - One strobe pulse per write: 001, 010, 100.
  - cfg_valid rises after the third write; STATUS reads 0x0000_0301.
- Write 0xFFFF_FFFF to 0x05, then to 0x13 → pslverr = 1 on both; no register change, no strobe, write count unchanged.
- WAIT_STATES = 2, write to 0x00 → pready low for 2 access cycles, high on the 3rd; mac1_cfg updates only after that edge.
- WAIT_STATES = 2: drop pselx during a wait cycle → FSM returns to IDLE, no commit, no strobe. A following normal transfer completes correctly.
- Assert presetn low during the access phase of a write to 0x12 → fir_cfg stays 0, pready = 0, cfg_valid = 0 after release.
